lcd_write_sequencer: RTL and testbench
======================================

Name: lcd_write_sequencer

Overview:
- Sequences all writes to the 16x2 HD44780 character LCD: a timed power-up init, then byte writes from one requester over a valid/ready handshake.
- Generates RS/DATA setup, the EN pulse, hold, and per-command execution waits.
- Sits between the message-generation logic and the LCD pins. The top level drives LCD_DATA onto the inout bus; the LCD is write-only (RW tied low).

Parameters:
- T_PWRUP, 750000, cycles to wait after reset before the first init command (15 ms at 50 MHz).
- T_SETUP, 2, cycles RS/DATA are stable before EN rises.
- T_EN, 16, cycles EN is held high.
- T_HOLD, 2, cycles RS/DATA are held after EN falls.
- T_CMD, 2000, execution wait for ordinary writes (40 us).
- T_CLR, 82000, execution wait for clear (0x01) or home (0x02) when RS=0 (1.64 ms).

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST_N  in  1  asynchronous active-low reset
- iDATA  in  8  byte to write
- iRS  in  1  0 = command, 1 = character data
- iVALID  in  1  request valid; held until accepted
- oREADY  out  1  sequencer can accept a byte
- iREINIT  in  1  single-cycle request to rerun the init sequence
- oINIT_DONE  out  1  init sequence complete
- LCD_DATA  out  8  LCD data bus
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  constant 0
- LCD_EN  out  1  LCD enable strobe

Behaviour:
- Reset (asynchronous, active-low): LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, oREADY=0, oINIT_DONE=0, state=PWRUP, timer loaded with T_PWRUP. Reset asserted mid-pulse forces EN low immediately, without waiting for a clock edge.
- All outputs are registered.
- States: PWRUP → INIT_LOAD → SETUP → EN_HI → HOLD → EXEC → (INIT_LOAD or IDLE).
- PWRUP: count T_PWRUP cycles, then go to INIT_LOAD.
- INIT_LOAD: load init ROM entry idx (0:0x38, 1:0x0C, 2:0x01, 3:0x06) with RS=0. After the EXEC of idx 3: oINIT_DONE=1, enter IDLE.
- Acceptance: accept = iVALID & oREADY & ~iREINIT at a rising edge. On the accept edge (edge 0):
  - iDATA/iRS are latched onto LCD_DATA/LCD_RS.
  - oREADY drops to 0.
  - State goes to SETUP.
- Write timing, edges counted from edge 0 (init writes follow the same timing):
  - EN rises at edge T_SETUP.
  - EN falls at edge T_SETUP+T_EN.
  - EXEC starts at edge T_SETUP+T_EN+T_HOLD.
  - oREADY rises at edge T_SETUP+T_EN+T_HOLD+T_EXEC.
  - T_EXEC = T_CLR if RS=0 and DATA∈{0x01,0x02}, else T_CMD.
- LCD_DATA/LCD_RS hold their value from the accept edge until the next accept. iDATA changes after acceptance have no effect.
- iVALID while oREADY=0 is ignored, not queued. The requester keeps it asserted.
- iREINIT: honoured only in IDLE. It has priority over a same-cycle iVALID; that byte is not accepted.
  - oREADY and oINIT_DONE drop at the next edge.
  - Init reruns from idx 0 without the PWRUP wait.
  - iREINIT outside IDLE is ignored.
- Timer: a single down-counter of width $clog2(max(T_PWRUP,T_CLR)+1), reloaded on each state entry; a phase ends when it reaches 1. All T_* parameters must be ≥1.

Decomposition:
- Package lcd_pkg holds:
  - HD44780 constants: LCD_FUNC_8B2L=8'h38, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_HOME=8'h02, LCD_ENTRY_INC=8'h06.
  - The state enum.
  - The 4-entry init ROM.
- One sub-module, lcd_delay_timer (load value, load strobe, done flag), is instantiated once.

Test Plan:
All scenarios use T_PWRUP=100, T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD=10, T_CLR=40.
1. Release reset → no EN for 100 cycles. Then EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0, each EN high exactly 4 cycles, with a 40-cycle wait after 0x01. oINIT_DONE=oREADY=1 exactly 202 cycles after reset release.
2. After init, write 0x41 with RS=1 → LCD_DATA=0x41, RS=1 from the accept edge. EN is high on edges 2–6. oREADY returns at edge 18.
3. Hold iVALID with 0x02/RS=0, then 0x80/RS=0 → first write takes 48 cycles. The second is accepted on the first edge oREADY=1 is sampled, and its EN rises 2 cycles later.
4. Toggle iDATA and iVALID while busy → LCD_DATA unchanged, no extra EN pulse, no acceptance.
5. Assert iRST_N=0 while EN is high, asynchronously between edges → EN=0, oREADY=0, oINIT_DONE=0 immediately. On release, the full 100-cycle PWRUP and init repeat.
6. In IDLE, pulse iREINIT together with iVALID (0x55) → 0x55 never appears on LCD_DATA. oINIT_DONE drops. The four init commands reissue immediately (first EN 2 cycles after INIT_LOAD). oINIT_DONE returns after 102 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared HD44780 command constants, sequencer state encoding and the power-up init ROM.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

    localparam logic [1:0] INIT_LAST_IDX = 2'd3;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT_LOAD,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } lcd_state_t;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] entry;
        case (idx)
            2'd0:    entry = LCD_FUNC_8B2L;
            2'd1:    entry = LCD_DISP_ON;
            2'd2:    entry = LCD_CLEAR;
            default: entry = LCD_ENTRY_INC;
        endcase
        return entry;
    endfunction

    // Clear and home need the long execution wait; everything else uses the short one.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Phase timer: down-counter reloaded on a strobe; done while the count sits at 1.
module lcd_delay_timer #(
    parameter int unsigned TW        = 20,
    parameter int unsigned RESET_VAL = 1
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iLOAD,
    input  logic [TW-1:0] iLOAD_VAL,
    output logic          oDONE
);

    logic [TW-1:0] count;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            count <= TW'(RESET_VAL);
        end else if (iLOAD) begin
            count <= iLOAD_VAL;
        end else if (count > TW'(1)) begin
            count <= count - TW'(1);
        end
    end

    assign oDONE = (count == TW'(1));

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 write sequencer: timed power-up init, then handshaked byte writes with
// setup / enable / hold / execution timing. All LCD-facing outputs are registered.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 16,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iVALID,
    output logic       oREADY,
    input  logic       iREINIT,
    output logic       oINIT_DONE,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    localparam int unsigned T_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    lcd_state_t    state, state_d, target;
    logic [1:0]    idx, idx_d;
    logic [7:0]    data_d;
    logic          rs_d;
    logic          init_done_d;
    logic          t_load;
    logic [TW-1:0] t_load_val;
    logic          t_done;

    lcd_delay_timer #(
        .TW        (TW),
        .RESET_VAL (T_PWRUP)
    ) u_timer (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iLOAD     (t_load),
        .iLOAD_VAL (t_load_val),
        .oDONE     (t_done)
    );

    assign LCD_RW = 1'b0;

    always_comb begin
        target      = state;
        state_d     = state;
        idx_d       = idx;
        data_d      = LCD_DATA;
        rs_d        = LCD_RS;
        init_done_d = oINIT_DONE;
        t_load_val  = '0;

        case (state)
            S_PWRUP: begin
                if (t_done) begin
                    idx_d  = '0;
                    target = S_INIT_LOAD;
                end
            end
            S_IDLE: begin
                if (iREINIT) begin
                    idx_d       = '0;
                    init_done_d = 1'b0;
                    target      = S_INIT_LOAD;
                end else if (iVALID && oREADY) begin
                    data_d = iDATA;
                    rs_d   = iRS;
                    target = S_SETUP;
                end
            end
            S_SETUP: if (t_done) target = S_EN_HI;
            S_EN_HI: if (t_done) target = S_HOLD;
            S_HOLD:  if (t_done) target = S_EXEC;
            S_EXEC: begin
                if (t_done) begin
                    if (oINIT_DONE) begin
                        target = S_IDLE;
                    end else if (idx == INIT_LAST_IDX) begin
                        init_done_d = 1'b1;
                        target      = S_IDLE;
                    end else begin
                        idx_d  = idx + 2'd1;
                        target = S_INIT_LOAD;
                    end
                end
            end
            default: target = S_INIT_LOAD;
        endcase

        // INIT_LOAD is resolved on the same edge that selects it, so the ROM byte is
        // latched exactly like an accepted request and init adds no extra cycles.
        if (target == S_INIT_LOAD) begin
            data_d  = init_rom(idx_d);
            rs_d    = 1'b0;
            state_d = S_SETUP;
        end else begin
            state_d = target;
        end

        t_load = (state_d != state);
        case (state_d)
            S_PWRUP: t_load_val = TW'(T_PWRUP);
            S_SETUP: t_load_val = TW'(T_SETUP);
            S_EN_HI: t_load_val = TW'(T_EN);
            S_HOLD:  t_load_val = TW'(T_HOLD);
            S_EXEC:  t_load_val = is_long_cmd(LCD_RS, LCD_DATA) ? TW'(T_CLR) : TW'(T_CMD);
            default: t_load_val = '0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_PWRUP;
            idx        <= '0;
            LCD_DATA   <= '0;
            LCD_RS     <= 1'b0;
            LCD_EN     <= 1'b0;
            oREADY     <= 1'b0;
            oINIT_DONE <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            LCD_DATA   <= data_d;
            LCD_RS     <= rs_d;
            LCD_EN     <= (state_d == S_EN_HI);
            oREADY     <= (state_d == S_IDLE);
            oINIT_DONE <= init_done_d;
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer: cycle-exact timing checks plus a scoreboard
// of expected EN-strobed bytes, popped on each EN falling edge.
module tb_lcd_write_sequencer;

    logic       iCLK    = 1'b0;
    logic       iRST_N  = 1'b1;
    logic [7:0] iDATA   = '0;
    logic       iRS     = 1'b0;
    logic       iVALID  = 1'b0;
    logic       iREINIT = 1'b0;
    logic       oREADY;
    logic       oINIT_DONE;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [8:0]  sb[$];

    lcd_write_sequencer #(
        .T_PWRUP (100),
        .T_SETUP (2),
        .T_EN    (4),
        .T_HOLD  (2),
        .T_CMD   (10),
        .T_CLR   (40)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iDATA      (iDATA),
        .iRS        (iRS),
        .iVALID     (iVALID),
        .oREADY     (oREADY),
        .iREINIT    (iREINIT),
        .oINIT_DONE (oINIT_DONE),
        .LCD_DATA   (LCD_DATA),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_EN     (LCD_EN)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push_init();
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h06});
    endtask

    // Called mid-cycle right after reset release; the next rising edge is edge 1.
    task automatic init_check();
        for (int unsigned k = 1; k <= 202; k++) begin
            step();
            if (k <= 102) chk("pwrup_en", LCD_EN, (k == 102));
            if (k == 100) chk("init_first_byte", LCD_DATA, 8'h38);
            chk("init_ready", oREADY, (k == 202));
            chk("init_done", oINIT_DONE, (k == 202));
        end
        chk("init_sb_empty", sb.size(), 0);
    endtask

    // mode 0: drop iVALID after accept; 1: keep iVALID/iDATA; 2: toggle inputs while busy.
    task automatic do_write(input logic [7:0] d, input logic r, input int unsigned mode);
        int unsigned total;
        total = 8 + (((r == 1'b0) && (d == 8'h01 || d == 8'h02)) ? 40 : 10);
        iDATA  = d;
        iRS    = r;
        iVALID = 1'b1;
        sb.push_back({r, d});
        step();
        chk("acc_data", LCD_DATA, d);
        chk("acc_rs", LCD_RS, r);
        chk("acc_ready", oREADY, 0);
        if (mode == 0) iVALID = 1'b0;
        for (int unsigned k = 1; k <= total; k++) begin
            if (mode == 2) begin
                iVALID  = 1'($urandom_range(0, 1));
                iDATA   = 8'($urandom);
                iREINIT = (k == 3);
            end
            step();
            chk("busy_data", LCD_DATA, d);
            chk("busy_rs", LCD_RS, r);
            chk("en_timing", LCD_EN, (k >= 2 && k < 6));
            chk("ready_timing", oREADY, (k == total));
            chk("init_done_held", oINIT_DONE, 1);
        end
        if (mode == 2) begin
            iVALID  = 1'b0;
            iREINIT = 1'b0;
            iDATA   = d;
        end
    endtask

    // EN monitor: every completed pulse must match the scoreboard head and be 4 cycles wide.
    initial begin
        logic        en_prev;
        int unsigned hi_cnt;
        logic [8:0]  exp;
        en_prev = 1'b0;
        hi_cnt  = 0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                en_prev = 1'b0;
                hi_cnt  = 0;
            end else begin
                if (LCD_EN) begin
                    hi_cnt++;
                end else if (en_prev) begin
                    if (sb.size() == 0) begin
                        chk("en_pulse_expected", sb.size(), 1);
                    end else begin
                        exp = sb.pop_front();
                        chk("en_pulse_byte", {LCD_RS, LCD_DATA}, exp);
                        chk("en_width", hi_cnt, 4);
                    end
                    hi_cnt = 0;
                end
                en_prev = LCD_EN;
            end
        end
    end

    initial begin
        // Reset state
        #1 iRST_N = 1'b0;
        #1;
        chk("rst_en", LCD_EN, 0);
        chk("rst_rs", LCD_RS, 0);
        chk("rst_data", LCD_DATA, 0);
        chk("rst_ready", oREADY, 0);
        chk("rst_init_done", oINIT_DONE, 0);
        chk("rst_rw", LCD_RW, 0);
        repeat (3) @(posedge iCLK);
        #2 iRST_N = 1'b1;
        push_init();
        init_check();

        // Single character write
        do_write(8'h41, 1'b1, 0);

        // Back-to-back: long home command, then set-DDRAM with iVALID held throughout
        do_write(8'h02, 1'b0, 1);
        do_write(8'h80, 1'b0, 0);

        // Busy-time noise on iDATA/iVALID/iREINIT must be ignored
        do_write(8'h7A, 1'b1, 2);
        step();
        chk("idle_after_noise", oREADY, 1);
        chk("sb_after_noise", sb.size(), 0);

        // Reinit in IDLE wins over a same-cycle request
        iDATA   = 8'h55;
        iRS     = 1'b1;
        iVALID  = 1'b1;
        iREINIT = 1'b1;
        push_init();
        step();
        iVALID  = 1'b0;
        iREINIT = 1'b0;
        chk("reinit_done_drop", oINIT_DONE, 0);
        chk("reinit_ready_drop", oREADY, 0);
        chk("reinit_data", LCD_DATA, 8'h38);
        chk("reinit_rs", LCD_RS, 0);
        for (int unsigned k = 1; k <= 102; k++) begin
            step();
            chk("reinit_no_55", (LCD_DATA == 8'h55), 0);
            if (k <= 2) chk("reinit_en", LCD_EN, (k == 2));
            chk("reinit_ready", oREADY, (k == 102));
            chk("reinit_done", oINIT_DONE, (k == 102));
        end
        chk("reinit_sb_empty", sb.size(), 0);

        // Asynchronous reset while EN is high
        iDATA  = 8'h33;
        iRS    = 1'b1;
        iVALID = 1'b1;
        step();
        iVALID = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_en", LCD_EN, 1);
        #2 iRST_N = 1'b0;
        #1;
        chk("async_rst_en", LCD_EN, 0);
        chk("async_rst_ready", oREADY, 0);
        chk("async_rst_done", oINIT_DONE, 0);
        sb.delete();
        repeat (2) @(posedge iCLK);
        #2 iRST_N = 1'b1;
        push_init();
        init_check();

        do_write(8'h01, 1'b0, 0);
        do_write(8'h01, 1'b1, 0);
        repeat (3) step();
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
